alu_pin_cmd_loader: RTL and testbench

- Pin-side responder for the ALU/decoder top: an external host drives bytes on the dedicated input pins and handshakes with a strobe bit.
- The block assembles opcode and operands, issues one ALU operation, then returns the result and flags byte by byte over the output pins.
- It sits between the top-level pin interface and the ALU core, and owns the whole pin protocol.

---
 rtl/alu_pin_cmd_loader.sv | 164 ++++++++++++++++
 tb/tb_alu_pin_cmd_loader.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/alu_pin_cmd_loader.sv
// rtl/alu_pin_cmd_loader.sv - pin-side byte protocol: load opcode/operands, run one ALU op, return result and flags
module alu_pin_cmd_loader #(
    parameter int OP_W    = 4,
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 7
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ena,
    input  logic [7:0]      data_in,
    input  logic            strb_in,
    output logic [7:0]      data_out,
    output logic            ack_out,
    output logic            busy_out,
    output logic            err_out,
    output logic [OP_W-1:0] alu_op,
    output logic [7:0]      alu_a,
    output logic [7:0]      alu_b,
    output logic            alu_start,
    input  logic            alu_done,
    input  logic [15:0]     alu_result,
    input  logic [3:0]      alu_flags
);

    typedef enum logic [2:0] {
        S_IDLE, S_GET_A, S_GET_B, S_ISSUE, S_WAIT, S_OUT_LO, S_OUT_HI, S_OUT_FL
    } state_t;

    state_t            state_q, state_d;
    logic              sync1_q, sync1_d;
    logic              sync2_q, sync2_d;
    logic              sync3_q, sync3_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic [7:0]        a_q, a_d;
    logic [7:0]        b_q, b_d;
    logic [15:0]       result_q, result_d;
    logic [3:0]        flags_q, flags_d;
    logic              err_q, err_d;
    logic              ack_q, ack_d;
    logic              busy_q, busy_d;
    logic [7:0]        dout_q, dout_d;
    logic              strb_edge;

    // Edges seen while disabled are dropped rather than queued.
    assign strb_edge = sync2_q & ~sync3_q & ena;

    always_comb begin
        state_d  = state_q;
        sync1_d  = strb_in;
        sync2_d  = sync1_q;
        sync3_d  = sync2_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        flags_d  = flags_q;
        err_d    = err_q;
        ack_d    = ack_q;
        dout_d   = dout_q;
        if (ena) begin
            case (state_q)
                S_IDLE: if (strb_edge) begin
                    op_d    = data_in[OP_W-1:0];
                    err_d   = 1'b0;
                    ack_d   = ~ack_q;
                    state_d = S_GET_A;
                end
                S_GET_A: if (strb_edge) begin
                    a_d     = data_in;
                    ack_d   = ~ack_q;
                    state_d = S_GET_B;
                end
                S_GET_B: if (strb_edge) begin
                    b_d     = data_in;
                    ack_d   = ~ack_q;
                    state_d = S_ISSUE;
                end
                S_ISSUE: begin
                    cnt_d   = '0;
                    state_d = S_WAIT;
                end
                S_WAIT: begin
                    cnt_d = cnt_q + CNT_W'(1);
                    // A done arriving on the final wait cycle still wins over the timeout.
                    if (alu_done) begin
                        result_d = alu_result;
                        flags_d  = alu_flags;
                        dout_d   = alu_result[7:0];
                        state_d  = S_OUT_LO;
                    end else if (cnt_d == CNT_W'(TIMEOUT - 1)) begin
                        result_d = '0;
                        flags_d  = '0;
                        err_d    = 1'b1;
                        dout_d   = '0;
                        state_d  = S_OUT_LO;
                    end
                end
                S_OUT_LO: if (strb_edge) begin
                    dout_d  = result_q[15:8];
                    ack_d   = ~ack_q;
                    state_d = S_OUT_HI;
                end
                S_OUT_HI: if (strb_edge) begin
                    dout_d  = {flags_q, 3'b000, err_q};
                    ack_d   = ~ack_q;
                    state_d = S_OUT_FL;
                end
                S_OUT_FL: if (strb_edge) begin
                    ack_d   = ~ack_q;
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
        busy_d = (state_d == S_ISSUE) || (state_d == S_WAIT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            sync3_q  <= 1'b0;
            cnt_q    <= '0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            flags_q  <= '0;
            err_q    <= 1'b0;
            ack_q    <= 1'b0;
            busy_q   <= 1'b0;
            dout_q   <= '0;
        end else begin
            state_q  <= state_d;
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            sync3_q  <= sync3_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            flags_q  <= flags_d;
            err_q    <= err_d;
            ack_q    <= ack_d;
            busy_q   <= busy_d;
            dout_q   <= dout_d;
        end
    end

    // Gated by ena so a pulse held off in ISSUE fires on the first enabled cycle.
    assign alu_start = ena && (state_q == S_ISSUE);
    assign data_out  = dout_q;
    assign ack_out   = ack_q;
    assign busy_out  = busy_q;
    assign err_out   = err_q;
    assign alu_op    = op_q;
    assign alu_a     = a_q;
    assign alu_b     = b_q;

endmodule

// File: tb/tb_alu_pin_cmd_loader.sv
// tb/tb_alu_pin_cmd_loader.sv - directed and randomized transactions against a transaction-level reference model
module tb_alu_pin_cmd_loader;

    localparam int TIMEOUT = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ena = 1'b1;
    logic [7:0]  data_in = 8'h00;
    logic        strb_in = 1'b0;
    logic [7:0]  data_out;
    logic        ack_out;
    logic        busy_out;
    logic        err_out;
    logic [3:0]  alu_op;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic        alu_start;
    logic        alu_done = 1'b0;
    logic [15:0] alu_result = 16'h0000;
    logic [3:0]  alu_flags = 4'h0;

    int   checks = 0;
    int   errors = 0;
    logic ack_model = 1'b0;

    alu_pin_cmd_loader #(.OP_W(4), .TIMEOUT(TIMEOUT), .CNT_W(7)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .data_in(data_in), .strb_in(strb_in),
        .data_out(data_out), .ack_out(ack_out), .busy_out(busy_out), .err_out(err_out),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_start(alu_start),
        .alu_done(alu_done), .alu_result(alu_result), .alu_flags(alu_flags)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        repeat (3) @(negedge clk);
        data_in = b;
        strb_in = 1'b1;
        n = 0;
        while (ack_out === ack_model && n < 10) begin
            @(negedge clk);
            n++;
        end
        ack_model = ~ack_model;
        check("ack_toggle", ack_out, ack_model);
        check("ack_latency", n, 3);
        strb_in = 1'b0;
    endtask

    // k = cycles after the start pulse at which the ALU answers; k >= TIMEOUT means never in time.
    task automatic run_txn(input logic [7:0] op_b, input logic [7:0] a, input logic [7:0] b,
                           input int k, input logic [15:0] res, input logic [3:0] flg,
                           input bit strobe_in_wait, input bit ena_gap);
        logic        late;
        logic [15:0] exp_res;
        logic [3:0]  exp_flg;
        logic [7:0]  exp_bytes [3];
        int          busy_n;
        int          i;
        late    = (k > TIMEOUT - 1);
        exp_res = late ? 16'h0000 : res;
        exp_flg = late ? 4'h0 : flg;
        exp_bytes[0] = exp_res[7:0];
        exp_bytes[1] = exp_res[15:8];
        exp_bytes[2] = {exp_flg, 3'b000, late};

        send_byte(op_b);
        check("op_after_byte0", alu_op, op_b[3:0]);
        check("err_cleared", err_out, 1'b0);
        if (ena_gap) begin
            ena = 1'b0;
            data_in = ~a;
            strb_in = 1'b1;
            repeat (5) @(negedge clk);
            strb_in = 1'b0;
            repeat (4) @(negedge clk);
            check("ena0_no_ack", ack_out, ack_model);
            ena = 1'b1;
        end
        send_byte(a);
        send_byte(b);
        check("start_pulse", alu_start, 1'b1);
        check("issue_op", alu_op, op_b[3:0]);
        check("issue_a", alu_a, a);
        check("issue_b", alu_b, b);
        check("issue_busy", busy_out, 1'b1);

        busy_n = 1;
        i = 0;
        while (i < TIMEOUT + 8) begin
            @(negedge clk);
            alu_done = 1'b0;
            i++;
            if (i == 1) check("start_one_cycle", alu_start, 1'b0);
            if (!busy_out) break;
            busy_n++;
            if (i == k) begin
                alu_done = 1'b1;
                alu_result = res;
                alu_flags = flg;
            end
            if (strobe_in_wait && i == 2) begin
                data_in = 8'h5A;
                strb_in = 1'b1;
            end
            if (strobe_in_wait && i == 6) strb_in = 1'b0;
        end
        strb_in = 1'b0;
        check("busy_cycles", busy_n, ((k < TIMEOUT - 1) ? k : TIMEOUT - 1) + 1);
        check("ack_after_wait", ack_out, ack_model);
        check("err_flag", err_out, late);
        for (int j = 0; j < 3; j++) begin
            check($sformatf("readout%0d", j), data_out, exp_bytes[j]);
            send_byte(8'($urandom));
        end
        check("err_held", err_out, late);
        check("idle_busy", busy_out, 1'b0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_data_out", data_out, 8'h00);
        check("rst_ack", ack_out, 1'b0);
        check("rst_busy", busy_out, 1'b0);
        check("rst_err", err_out, 1'b0);
        check("rst_alu_op", alu_op, 4'h0);
        check("rst_alu_a", alu_a, 8'h00);
        check("rst_alu_b", alu_b, 8'h00);
        check("rst_start", alu_start, 1'b0);
        rst_n = 1'b1;

        run_txn(8'h03, 8'h25, 8'h17, 2, 16'h003C, 4'b0000, 1'b0, 1'b0);
        run_txn(8'hA5, 8'h11, 8'h22, 1000, 16'hBEEF, 4'hF, 1'b1, 1'b0);
        run_txn(8'hF9, 8'h40, 8'h41, 5, 16'hFF80, 4'b0110, 1'b0, 1'b1);
        run_txn(8'h07, 8'h99, 8'h66, TIMEOUT - 1, 16'h1234, 4'b1010, 1'b0, 1'b0);

        send_byte(8'h02);
        send_byte(8'h33);
        send_byte(8'h44);
        repeat (5) @(negedge clk);
        check("pre_rst_busy", busy_out, 1'b1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_data_out", data_out, 8'h00);
        check("mid_rst_ack", ack_out, 1'b0);
        check("mid_rst_busy", busy_out, 1'b0);
        check("mid_rst_alu_a", alu_a, 8'h00);
        check("mid_rst_alu_op", alu_op, 4'h0);
        check("mid_rst_start", alu_start, 1'b0);
        ack_model = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        run_txn(8'h0C, 8'h01, 8'h02, 3, 16'h8001, 4'b1001, 1'b0, 1'b0);

        for (int t = 0; t < 12; t++) begin
            run_txn(8'($urandom), 8'($urandom), 8'($urandom),
                    int'($urandom_range(1, TIMEOUT + 3)), 16'($urandom), 4'($urandom),
                    1'b0, ($urandom_range(0, 3) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
